// File: rtl/shared_adder_sched.sv
// Round-robin scheduler sharing one W-bit adder among NREQ requesters.
// Grant one cycle after request; registered sum/cout/id one cycle after grant.
module shared_adder_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        opa,
    input  logic [NREQ*W-1:0]        opb,
    output logic [NREQ-1:0]          gnt,
    output logic [W-1:0]             res,
    output logic                     cout,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opa_q, opa_d, opb_q, opb_d;
    logic [W-1:0]    res_q, res_d;
    logic            cout_q, cout_d;
    logic            vld_q, vld_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  win_q, win_d, ptr_q, ptr_d, id_q, id_d;

    logic [IDW-1:0]  pick;
    logic            pick_vld;
    logic [IDW-1:0]  idx_v;
    int              idx;
    logic [W:0]      sum;

    // First asserted request at or after ptr_q, wrapping modulo NREQ.
    always_comb begin : arb
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        idx_v    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_v = IDW'(idx);
            if (!pick_vld && req[idx_v]) begin
                pick     = idx_v;
                pick_vld = 1'b1;
            end
        end
    end

    assign sum = {1'b0, opa_q} + {1'b0, opb_q};

    always_comb begin : fsm
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        res_d   = res_q;
        cout_d  = cout_q;
        id_d    = id_q;
        gnt_d   = '0;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && pick_vld) begin
                    opa_d   = opa[int'(pick)*W +: W];
                    opb_d   = opb[int'(pick)*W +: W];
                    gnt_d   = NREQ'(1) << pick;
                    win_d   = pick;
                    ptr_d   = (int'(pick) == NREQ-1) ? '0 : pick + 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // ena is deliberately ignored here: a captured op always completes.
                res_d   = sum[W-1:0];
                cout_d  = sum[W];
                id_d    = win_q;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt       = gnt_q;
    assign res       = res_q;
    assign cout      = cout_q;
    assign res_valid = vld_q;
    assign res_id    = id_q;
    assign busy      = (state_q == EXEC);

endmodule
